// File: rtl/fnd_scan_driver.sv
// Binary-to-BCD converter (sequential shift-add-3) feeding a 4-digit multiplexed FND scanner.
// Optional FND_LEAD_ZERO_BLANK_EN blanks leading zero digits on o_bcd.
module fnd_scan_driver #(
  parameter int SCAN_DIV  = 100000,
  parameter int BIN_WIDTH = 14
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [BIN_WIDTH-1:0] i_bin,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_ovf,
  output logic [3:0]           o_bcd,
  output logic [3:0]           o_digit_sel
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] TC = CW'(SCAN_DIV - 1);
  localparam logic [BIN_WIDTH-1:0] MAX_VAL = BIN_WIDTH'(9999);
  localparam logic [3:0] LAST_BIT = 4'(BIN_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t               state;
  logic [BIN_WIDTH-1:0] v;
  logic [15:0]          scratch;
  logic [15:0]          disp;
  logic [3:0]           bitcnt;
  logic [15:0]          adj;
  logic [CW-1:0]        cnt;
  logic [1:0]           idx;
  logic [3:0]           shown [4];

  always_comb begin
    adj = scratch;
    for (int unsigned i = 0; i < 4; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_ovf   <= 1'b0;
      v       <= '0;
      scratch <= '0;
      bitcnt  <= '0;
      disp    <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            v       <= (i_bin > MAX_VAL) ? MAX_VAL : i_bin;
            o_ovf   <= (i_bin > MAX_VAL);
            scratch <= '0;
            bitcnt  <= '0;
            o_busy  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // adj[15] is always clear for inputs <= 9999, so dropping it loses nothing
          {scratch, v} <= {adj[14:0], v, 1'b0};
          bitcnt       <= bitcnt + 4'd1;
          if (bitcnt == LAST_BIT) state <= COMMIT;
        end
        COMMIT: begin
          disp   <= scratch;
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) shown[i] = disp[4*i +: 4];
`ifdef FND_LEAD_ZERO_BLANK_EN
    if (disp[15:12] == 4'd0) shown[3] = 4'hF;
    if (disp[15:8]  == 8'd0) shown[2] = 4'hF;
    if (disp[15:4]  == 12'd0) shown[1] = 4'hF;
`endif
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt         <= '0;
      idx         <= '0;
      o_bcd       <= 4'hF;
      o_digit_sel <= 4'b1111;
    end else begin
      if (cnt == TC) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      o_digit_sel <= ~(4'b0001 << idx);
      o_bcd       <= shown[idx];
    end
  end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Scoreboard bench for fnd_scan_driver with SCAN_DIV=4; honours FND_LEAD_ZERO_BLANK_EN.
module tb_fnd_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] i_bin;
  logic        i_start;
  logic        o_busy, o_done, o_ovf;
  logic [3:0]  o_bcd, o_digit_sel;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          shown_val = 0;

  typedef struct {
    int unsigned due;
    int          val;
    logic        ovf;
  } exp_t;
  exp_t sb[$];

  fnd_scan_driver #(.SCAN_DIV(4), .BIN_WIDTH(14)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_bin(i_bin), .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done), .o_ovf(o_ovf),
    .o_bcd(o_bcd), .o_digit_sel(o_digit_sel)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] exp_digit(input int val, input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
`ifdef FND_LEAD_ZERO_BLANK_EN
    if (k > 0 && val < p) return 4'hF;
`endif
    return 4'((val / p) % 10);
  endfunction

  function automatic int sel_idx(input logic [3:0] sel);
    case (sel)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  always @(negedge clk) begin
    if (o_done === 1'b1) begin
      if (sb.size() == 0) check("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", cyc, e.due);
        check("ovf", o_ovf, e.ovf);
      end
    end
  end

  task automatic capture(input int val);
    logic [3:0] got [4];
    int bad = 0;
    for (int k = 0; k < 4; k++) got[k] = 4'hx;
    for (int n = 0; n < 16; n++) begin
      int id;
      @(negedge clk);
      id = sel_idx(o_digit_sel);
      if (id < 0) bad++;
      else got[id] = o_bcd;
    end
    for (int k = 0; k < 4; k++) check($sformatf("digit%0d_of_%0d", k, val), got[k], exp_digit(val, k));
    check("sel_onehot", bad, 0);
  endtask

  task automatic convert(input int val, input bit interfere);
    int busy_cnt = 0;
    bit seen = 0;
    int sat = (val > 9999) ? 9999 : val;
    @(negedge clk);
    i_bin   = 14'(val);
    i_start = 1'b1;
    sb.push_back('{cyc + 16, sat, (val > 9999)});
    for (int t = 1; t <= 40 && !seen; t++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (interfere && t == 5)  begin i_bin = 14'd7777; i_start = 1'b1; end
      if (interfere && t == 15) begin i_bin = 14'd1111; i_start = 1'b1; end
      if (interfere && t == 8) begin
        int id;
        id = sel_idx(o_digit_sel);
        check("hold_old_display", o_bcd, exp_digit(shown_val, (id < 0) ? 0 : id));
      end
      if (o_busy) busy_cnt++;
      if (o_done) seen = 1;
    end
    i_start = 1'b0;
    check("done_seen", seen, 1);
    check("busy_cycles", busy_cnt, 15);
    shown_val = sat;
    capture(sat);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    i_bin   = '0;
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bcd", o_bcd, 4'hF);
    check("rst_sel", o_digit_sel, 4'b1111);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_ovf", o_ovf, 0);
    rst_n = 1'b1;

    // Edge j after release shows digit ((j-1)/4)%4
    for (int j = 1; j <= 20; j++) begin
      int id;
      logic [3:0] sel_exp;
      @(negedge clk);
      id = ((j - 1) / 4) % 4;
      sel_exp = ~(4'b0001 << id);
      check($sformatf("scan_sel_%0d", j), o_digit_sel, sel_exp);
      check($sformatf("scan_bcd_%0d", j), o_bcd, exp_digit(0, id));
    end

    convert(1234, 1'b0);
    convert(12000, 1'b0);
    convert(5, 1'b0);
    convert(4321, 1'b1);
    repeat (20) @(negedge clk);

    // Reset mid-conversion aborts without a done pulse
    @(negedge clk);
    i_bin   = 14'd9999;
    i_start = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      @(negedge clk);
      i_start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", o_busy, 0);
    check("abort_done", o_done, 0);
    check("abort_ovf", o_ovf, 0);
    check("abort_sel", o_digit_sel, 4'b1111);
    check("abort_bcd", o_bcd, 4'hF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    shown_val = 0;
    repeat (20) @(negedge clk);
    capture(0);
    convert(42, 1'b0);

    repeat (20) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
